audio_frame_fifo: RTL

- Parametrised multi-channel successor to the fixed two-entry per-channel audio FIFOs in audioport.
- Bus side writes individual channel samples; the block assembles them into frames and stores up to DEPTH complete frames.
- On each sample tick, the playback side pops one whole frame, all channels at once.
- Provides fill level, full/empty, watermark refill request and sticky overflow/underflow flags for the status logic and IRQ generation.

---
 rtl/audio_frame_fifo_if.sv | 40 ++++
 rtl/audio_frame_fifo.sv | 139 +++++++++++++
 2 files changed

// File: rtl/audio_frame_fifo_if.sv
// Purpose : bus/playback signal bundle for audio_frame_fifo (write side, tick side, status).
// Latency : n/a (wires only).
// Backpressure: none in-band; the producer watches level_out/full_out/req_out.
// Ports   : master drives clr/wr/tick/threshold and samples frame + status;
//           slave is the FIFO side.
interface audio_frame_fifo_if #(
    parameter int DATA_WIDTH = 24,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 4
);
    localparam int LEVEL_WIDTH = $clog2(DEPTH + 1);
    localparam int CH_WIDTH    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                           clr_in;
    logic                           wr_in;
    logic [CH_WIDTH-1:0]            wr_ch_in;
    logic [DATA_WIDTH-1:0]          wr_data_in;
    logic                           tick_in;
    logic [LEVEL_WIDTH-1:0]         threshold_in;
    logic [CHANNELS*DATA_WIDTH-1:0] audio_out;
    logic                           valid_out;
    logic [LEVEL_WIDTH-1:0]         level_out;
    logic                           full_out;
    logic                           empty_out;
    logic                           req_out;
    logic                           overflow_out;
    logic                           underflow_out;

    modport master (
        output clr_in, wr_in, wr_ch_in, wr_data_in, tick_in, threshold_in,
        input  audio_out, valid_out, level_out, full_out, empty_out,
               req_out, overflow_out, underflow_out
    );

    modport slave (
        input  clr_in, wr_in, wr_ch_in, wr_data_in, tick_in, threshold_in,
        output audio_out, valid_out, level_out, full_out, empty_out,
               req_out, overflow_out, underflow_out
    );
endinterface

// File: rtl/audio_frame_fifo.sv
// Purpose : assembles per-channel sample writes into frames, stores DEPTH frames, pops a whole frame per tick.
// Latency : commit visible in level_out next cycle; tick -> audio_out/valid_out next cycle.
// Backpressure: none; a frame completed while full (and not popped) is dropped and flagged as overflow.
// Ports   : clk, rst (sync, active-high); bus (slave modport) carries clear, channel writes,
//           tick, watermark, popped frame, level/full/empty, refill request and sticky error flags.
module audio_frame_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst,
    audio_frame_fifo_if.slave  bus
);
    localparam int LEVEL_WIDTH = $clog2(DEPTH + 1);
    localparam int CH_WIDTH    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int FRAME_WIDTH = CHANNELS * DATA_WIDTH;

    // One extra bit so the channel count itself is representable for the range check.
    localparam logic [CH_WIDTH:0]        CH_COUNT  = (CH_WIDTH + 1)'(CHANNELS);
    localparam logic [LEVEL_WIDTH-1:0]   LEVEL_MAX = LEVEL_WIDTH'(DEPTH);

    logic [FRAME_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0]  stage_dat [CHANNELS];
    logic [CHANNELS-1:0]    stage_bits;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [LEVEL_WIDTH-1:0] level_q;
    logic                   full_q;
    logic                   empty_q;
    logic [FRAME_WIDTH-1:0] audio_q;
    logic                   valid_q;
    logic                   req_q;
    logic                   overflow_q;
    logic                   underflow_q;

    logic                   clear;
    logic                   wr_ok;
    logic [CHANNELS-1:0]    wr_onehot;
    logic [CHANNELS-1:0]    new_bits;
    logic                   commit;
    logic                   pop;
    logic                   accept;
    logic [FRAME_WIDTH-1:0] commit_frame;
    logic [LEVEL_WIDTH-1:0] level_next;

    assign clear = rst || bus.clr_in;
    assign wr_ok = bus.wr_in && ({1'b0, bus.wr_ch_in} < CH_COUNT);

    always_comb begin
        wr_onehot    = '0;
        commit_frame = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_onehot[c] = wr_ok && (bus.wr_ch_in == CH_WIDTH'(c));
        end
        // The write that completes a frame is merged straight into the committed frame.
        for (int c = 0; c < CHANNELS; c++) begin
            commit_frame[c*DATA_WIDTH +: DATA_WIDTH] =
                wr_onehot[c] ? bus.wr_data_in : stage_dat[c];
        end
        new_bits = stage_bits | wr_onehot;
        commit   = wr_ok && (&new_bits);
        // Pop decision uses the registered level, so a same-cycle commit cannot feed the tick.
        pop      = bus.tick_in && (level_q != '0);
        // When full, a same-cycle pop frees the slot the new frame lands in.
        accept   = commit && (!full_q || pop);
        level_next = level_q + LEVEL_WIDTH'(accept) - LEVEL_WIDTH'(pop);
    end

    // Frame storage carries no reset; validity is tracked by the pointers and level.
    // On a full commit+pop, wr_ptr == rd_ptr: the read below sees the old (oldest) frame.
    always_ff @(posedge clk) begin
        if (!clear && accept) begin
            mem[wr_ptr] <= commit_frame;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                stage_dat[c] <= '0;
            end
            stage_bits  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            audio_q     <= '0;
            valid_q     <= 1'b0;
            req_q       <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_onehot[c]) begin
                    stage_dat[c] <= bus.wr_data_in;
                end
            end
            // Staging restarts after every completed frame, accepted or dropped.
            if (wr_ok) begin
                stage_bits <= commit ? '0 : new_bits;
            end

            if (accept) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (commit && !accept) begin
                overflow_q <= 1'b1;
            end

            valid_q <= bus.tick_in;
            if (pop) begin
                audio_q <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_WIDTH'(1);
            end else if (bus.tick_in) begin
                audio_q     <= '0;
                underflow_q <= 1'b1;
            end

            // Crossing test: an unchanged level can never cross, so commit+pop is silent.
            req_q   <= pop && (level_q > bus.threshold_in) && (level_next <= bus.threshold_in);
            level_q <= level_next;
            full_q  <= (level_next == LEVEL_MAX);
            empty_q <= (level_next == '0);
        end
    end

    assign bus.audio_out     = audio_q;
    assign bus.valid_out     = valid_q;
    assign bus.level_out     = level_q;
    assign bus.full_out      = full_q;
    assign bus.empty_out     = empty_q;
    assign bus.req_out       = req_q;
    assign bus.overflow_out  = overflow_q;
    assign bus.underflow_out = underflow_q;
endmodule
